tm1638_responder: RTL

Synthesizable TM1638 device-side responder: the chip end of the STB/CLK/DIO serial link that the host-side tm1638 driver and top-level sequencer talk to. Decodes the data, address and display-control commands, holds the 16-byte display RAM and the display-control register, and shifts out 4 key-scan bytes on read commands. Used as a bench peer for the host driver and as an FPGA-side TM1638 emulator feeding a local segment/LED renderer.

---
 rtl/tm1638_responder_if.sv | 19 +
 rtl/tm1638_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder_if.sv
// TM1638 serial link bundle: the STB/CLK/DIO pins between a host driver and
// the device-side responder. DIO is split into host-to-device data (dio_in)
// and device-to-host data with an output enable (dio_out/dio_oe), so the
// tri-state pad can live outside this bundle.
//   stb     : chip select, active low (host -> device)
//   sclk    : serial clock, idle high (host -> device)
//   dio_in  : serial data, LSB first, sampled on sclk rising edge
//   dio_out : key-scan data from the device
//   dio_oe  : high while the device drives DIO
interface tm1638_responder_if;
    logic stb;
    logic sclk;
    logic dio_in;
    logic dio_out;
    logic dio_oe;

    modport master (output stb, output sclk, output dio_in, input dio_out, input dio_oe);
    modport slave  (input stb, input sclk, input dio_in, output dio_out, output dio_oe);
endinterface

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder. Oversamples the host's STB/CLK/DIO link with
// the local clock, decodes data/address/display-control commands, keeps the
// 16-byte display RAM and display-control register, and shifts a 32-bit key
// snapshot back to the host on read commands.
//   clk, rst_n  : system clock (>= 4x sclk), asynchronous active-low reset
//   bus         : serial link (slave side)
//   key_scan    : key matrix snapshot, byte0 = bits[7:0] sent first
//   disp_ram    : display RAM, address n at bits[8n+7:8n]
//   disp_on     : display enable, disp_bright: brightness level
//   wr_strobe   : one-cycle pulse per RAM byte written, wr_addr its address
//   key_rd      : one-cycle pulse when a read command is accepted
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tm1638_responder_if.slave        bus,
    input  logic [31:0]              key_scan,
    output logic [127:0]             disp_ram,
    output logic                     disp_on,
    output logic [2:0]               disp_bright,
    output logic                     wr_strobe,
    output logic [3:0]               wr_addr,
    output logic                     key_rd
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA_WR,
        ST_KEY_RD,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
    logic        stb_prev_q, stb_prev_d;
    logic        sclk_prev_q, sclk_prev_d;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        mode_read_q, mode_read_d;
    logic        mode_fixed_q, mode_fixed_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] snap_q, snap_d;
    logic [5:0]  key_idx_q, key_idx_d;
    logic        dio_out_q, dio_out_d;
    logic        dio_oe_q, dio_oe_d;
    logic        disp_on_q, disp_on_d;
    logic [2:0]  disp_bright_q, disp_bright_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic        key_rd_q, key_rd_d;
    logic [7:0]  ram_q [16];
    logic [7:0]  ram_d [16];

    logic        stb_s, sclk_s, dio_s;
    logic        sclk_rise, sclk_fall, stb_rise, stb_fall, byte_done;
    logic [7:0]  byte_val;

    assign stb_sync_d  = {stb_sync_q[SYNC_STAGES-2:0],  bus.stb};
    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    assign dio_sync_d  = {dio_sync_q[SYNC_STAGES-2:0],  bus.dio_in};
    assign stb_prev_d  = stb_s;
    assign sclk_prev_d = sclk_s;

    assign stb_s     = stb_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign dio_s     = dio_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign stb_rise  = stb_s & ~stb_prev_q;
    assign stb_fall  = ~stb_s & stb_prev_q;
    // dio is delayed by the same number of stages as sclk, so dio_s is the
    // value present at the host's rising edge.
    assign byte_val  = {dio_s, shift_q[7:1]};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        mode_read_d   = mode_read_q;
        mode_fixed_d  = mode_fixed_q;
        addr_d        = addr_q;
        snap_d        = snap_q;
        key_idx_d     = key_idx_q;
        dio_out_d     = dio_out_q;
        dio_oe_d      = dio_oe_q;
        disp_on_d     = disp_on_q;
        disp_bright_d = disp_bright_q;
        wr_strobe_d   = 1'b0;
        wr_addr_d     = wr_addr_q;
        key_rd_d      = 1'b0;
        ram_d         = ram_q;

        // A closing stb beats any same-cycle sclk edge, so a half-finished
        // byte never takes effect.
        if (stb_rise) begin
            state_d   = ST_IDLE;
            dio_oe_d  = 1'b0;
            dio_out_d = 1'b1;
        end else if (!stb_s) begin
            if (state_q != ST_IDLE && sclk_rise) begin
                shift_d   = byte_val;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (stb_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        case (byte_val[7:6])
                            2'b01: begin
                                mode_read_d  = byte_val[1];
                                mode_fixed_d = byte_val[2];
                                if (byte_val[1]) begin
                                    snap_d    = key_scan;
                                    key_rd_d  = 1'b1;
                                    key_idx_d = 6'd0;
                                    state_d   = ST_KEY_RD;
                                end else begin
                                    state_d   = ST_IGNORE;
                                end
                            end
                            2'b10: begin
                                disp_on_d     = byte_val[3];
                                disp_bright_d = byte_val[2:0];
                                state_d       = ST_IGNORE;
                            end
                            2'b11: begin
                                addr_d  = byte_val[3:0];
                                state_d = ST_DATA_WR;
                            end
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_DATA_WR: begin
                    // Bytes arriving while the stored mode is "read" are dropped.
                    if (byte_done && !mode_read_q) begin
                        ram_d[addr_q] = byte_val;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = addr_q;
                        if (!mode_fixed_q) begin
                            addr_d = addr_q + 4'd1;
                        end
                    end
                end
                ST_KEY_RD: begin
                    if (sclk_fall) begin
                        if (key_idx_q[5]) begin
                            dio_oe_d = 1'b0;
                            state_d  = ST_IGNORE;
                        end else begin
                            dio_oe_d  = 1'b1;
                            dio_out_d = snap_q[key_idx_q[4:0]];
                            key_idx_d = key_idx_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync_q    <= '1;
            sclk_sync_q   <= '1;
            dio_sync_q    <= '0;
            stb_prev_q    <= 1'b1;
            sclk_prev_q   <= 1'b1;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            mode_read_q   <= 1'b0;
            mode_fixed_q  <= 1'b0;
            addr_q        <= 4'd0;
            snap_q        <= 32'h0;
            key_idx_q     <= 6'd0;
            dio_out_q     <= 1'b1;
            dio_oe_q      <= 1'b0;
            disp_on_q     <= 1'b0;
            disp_bright_q <= 3'd0;
            wr_strobe_q   <= 1'b0;
            wr_addr_q     <= 4'd0;
            key_rd_q      <= 1'b0;
            for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
        end else begin
            stb_sync_q    <= stb_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            dio_sync_q    <= dio_sync_d;
            stb_prev_q    <= stb_prev_d;
            sclk_prev_q   <= sclk_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            mode_read_q   <= mode_read_d;
            mode_fixed_q  <= mode_fixed_d;
            addr_q        <= addr_d;
            snap_q        <= snap_d;
            key_idx_q     <= key_idx_d;
            dio_out_q     <= dio_out_d;
            dio_oe_q      <= dio_oe_d;
            disp_on_q     <= disp_on_d;
            disp_bright_q <= disp_bright_d;
            wr_strobe_q   <= wr_strobe_d;
            wr_addr_q     <= wr_addr_d;
            key_rd_q      <= key_rd_d;
            for (int i = 0; i < 16; i++) ram_q[i] <= ram_d[i];
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_ram_out
        assign disp_ram[8*gi +: 8] = ram_q[gi];
    end

    assign bus.dio_out = dio_out_q;
    assign bus.dio_oe  = dio_oe_q;
    assign disp_on     = disp_on_q;
    assign disp_bright = disp_bright_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign key_rd      = key_rd_q;
endmodule
